// File: rtl/cbus_sram_ctrl.sv
// cbus_sram_ctrl: CBus slave endpoint backed by a single-port synchronous
// SRAM with 1-cycle read latency. Single and burst (1..16 beat) transfers;
// reads stream one beat per cycle after a 2-cycle start-up, writes complete
// one beat per cycle. Burst addresses wrap at the top of the SRAM.
// Optional build macro: CBUS_SRAM_RANGE_CHECK_EN adds out-of-range
// detection (suppressed writes, 32'hDEAD_BEEF read data) and a sticky err port.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_ctrl
  import cbus_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  cbus_req_t            creq,
  output cbus_resp_t           cresp,
  output logic                 sram_en,
  output logic [3:0]           sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata
`ifdef CBUS_SRAM_RANGE_CHECK_EN
  ,
  output logic                 err
`endif
);

  typedef enum logic [1:0] {IDLE, RADDR, RDATA, WRITE} state_t;

  state_t               state_reg, state_next;
  logic [ADDR_BITS-1:0] base_reg;
  logic [3:0]           len_reg;
  logic [3:0]           cnt_reg;
  logic                 oor_reg;
  logic                 is_last;
  logic [ADDR_BITS-1:0] beat_addr;
  logic [ADDR_BITS-1:0] next_addr;
  logic                 capture;

  // Address bits [1:0] select bytes within a word and are never used.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^creq.addr[1:0];

  assign capture   = (state_reg == IDLE) && creq.valid;
  assign is_last   = (cnt_reg == len_reg);
  // Natural ADDR_BITS-wide overflow gives the wrap at the top of the SRAM.
  assign beat_addr = base_reg + ADDR_BITS'(cnt_reg);
  assign next_addr = beat_addr + ADDR_BITS'(1);

`ifdef CBUS_SRAM_RANGE_CHECK_EN
  logic oor_in;
  logic err_reg;
  assign oor_in = |creq.addr[31:ADDR_BITS+2];
  assign err    = err_reg;

  // Remember whether the captured request is out of range; err is sticky.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      oor_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (capture) begin
      oor_reg <= oor_in;
      if (oor_in) err_reg <= 1'b1;
    end
  end
`else
  // Without range checking the upper address bits alias modulo capacity.
  logic unused_addr_msb;
  assign unused_addr_msb = ^creq.addr[31:ADDR_BITS+2];
  assign oor_reg = 1'b0;
`endif

  // State, captured request and beat counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        base_reg <= creq.addr[ADDR_BITS+1:2];
        len_reg  <= creq.len;
        cnt_reg  <= '0;
      end else if (state_reg == RDATA || state_reg == WRITE) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  // Next state and all outputs; everything is held at zero while in reset
  // so no SRAM write can occur during a reset cycle.
  always_comb begin
    state_next = state_reg;
    cresp      = '0;
    sram_en    = 1'b0;
    sram_we    = 4'h0;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    if (resetn) begin
      case (state_reg)
        IDLE: begin
          if (creq.valid) state_next = creq.is_write ? WRITE : RADDR;
        end
        RADDR: begin
          sram_en    = 1'b1;
          sram_addr  = base_reg;
          state_next = RDATA;
        end
        RDATA: begin
          cresp.ready = 1'b1;
          cresp.last  = is_last;
          cresp.data  = oor_reg ? 32'hDEAD_BEEF : sram_rdata;
          if (is_last) begin
            state_next = IDLE;
          end else begin
            // Prefetch the next beat so data streams one beat per cycle.
            sram_en   = 1'b1;
            sram_addr = next_addr;
          end
        end
        WRITE: begin
          sram_en     = 1'b1;
          sram_addr   = beat_addr;
          sram_wdata  = creq.data;
          sram_we     = oor_reg ? 4'h0 : creq.strobe;
          cresp.ready = 1'b1;
          cresp.last  = is_last;
          if (is_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_sram_ctrl.sv
// tb_cbus_sram_ctrl: randomized and directed bench for cbus_sram_ctrl.
// A transaction-level reference memory predicts read data; per-beat timing,
// addresses and strobes are derived from the transfer rules directly.
`timescale 1ns/1ps
module tb_cbus_sram_ctrl;
  import cbus_pkg::*;

  localparam int AB    = 14;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          resetn;
  cbus_req_t     creq;
  cbus_resp_t    cresp;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AB-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
`ifdef CBUS_SRAM_RANGE_CHECK_EN
  logic          err;
`endif

  cbus_sram_ctrl #(.ADDR_BITS(AB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .creq       (creq),
    .cresp      (cresp),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef CBUS_SRAM_RANGE_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  int checks   = 0;
  int failures = 0;

  // Environment SRAM: byte-write, registered read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'h0) sram_rdata <= sram_mem[sram_addr];
      else
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef CBUS_SRAM_RANGE_CHECK_EN
    return a[31:AB+2] != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_resp"}, 64'(cresp), 64'h0);
    check({tag, "_sram"}, {13'h0, sram_en, sram_we, 14'(sram_addr), sram_wdata}, 64'h0);
  endtask

  // One CBus transaction. fix=1 uses fd/fs on every write beat, otherwise
  // random data/strobe per beat. abort_at>=0 asserts reset at that beat.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input int len,
                        input bit fix, input logic [31:0] fd, input logic [3:0] fs,
                        input int abort_at);
    int          base, a;
    bit          oor;
    logic [3:0]  stb;
    logic [31:0] d, exp_d;
    base = int'((addr >> 2) % DEPTH);
    oor  = out_of_range(addr);
    @(negedge clk);
    resetn        = 1'b1;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.addr     = addr;
    creq.len      = 4'(len);
    creq.strobe   = 4'($urandom);
    creq.data     = $urandom;
    #1;
    check("idle", {58'h0, cresp.ready, sram_en, sram_we}, 64'h0);
    if (wr) begin
      for (int k = 0; k <= len; k++) begin
        @(negedge clk);
        if (k == abort_at) begin
          resetn = 1'b0;
          #1;
          check_quiet("rst_mid");
          repeat (2) begin
            @(negedge clk);
            #1;
            check_quiet("rst_hold");
          end
          $display("txn write addr=%h len=%0d aborted at beat %0d", addr, len, k);
          return;
        end
        stb = fix ? fs : 4'($urandom);
        d   = fix ? fd : $urandom;
        creq.strobe = stb;
        creq.data   = d;
        #1;
        a = (base + k) % DEPTH;
        check("wr_ctl", {57'h0, cresp.ready, cresp.last, sram_en, sram_we},
              {57'h0, 1'b1, (k == len), 1'b1, (oor ? 4'h0 : stb)});
        check("wr_addr", 64'(sram_addr), 64'(a));
        check("wr_data", 64'(sram_wdata), 64'(d));
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (stb[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end
      $display("txn write addr=%h len=%0d", addr, len);
    end else begin
      @(negedge clk);
      #1;
      check("raddr", {44'h0, cresp.ready, sram_en, sram_we, 14'(sram_addr)},
            {44'h0, 1'b0, 1'b1, 4'h0, 14'(base)});
      for (int k = 0; k <= len; k++) begin
        @(negedge clk);
        #1;
        a     = (base + k) % DEPTH;
        exp_d = oor ? 32'hDEAD_BEEF : ref_mem[a];
        check("rd_ctl", {62'h0, cresp.ready, cresp.last}, {62'h0, 1'b1, (k == len)});
        check("rd_data", 64'(cresp.data), 64'(exp_d));
      end
      $display("txn read  addr=%h len=%0d", addr, len);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      creq.valid = 1'b0;
      #1;
      check("gap", {58'h0, cresp.ready, sram_en, sram_we}, 64'h0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = $urandom;
      sram_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      ref_mem[64 + i]  = 32'(i + 1);
      sram_mem[64 + i] = 32'(i + 1);
    end
    sram_rdata = 32'h0;

    // Reset with a write request held valid.
    resetn        = 1'b0;
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.addr     = 32'h10;
    creq.strobe   = 4'hF;
    creq.data     = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_quiet("rst");
    end
`ifdef CBUS_SRAM_RANGE_CHECK_EN
    check("err_rst", 64'(err), 64'h0);
`endif

    do_txn(1'b1, 32'h10, 0, 1'b1, 32'h1234_5678, 4'hF, -1);
    do_txn(1'b0, 32'h10, 0, 1'b0, 32'h0, 4'h0, -1);
    do_txn(1'b1, 32'h10, 0, 1'b1, 32'hAABB_CCDD, 4'b0010, -1);
    do_txn(1'b0, 32'h10, 0, 1'b0, 32'h0, 4'h0, -1);
    do_txn(1'b0, 32'h100, 3, 1'b0, 32'h0, 4'h0, -1);
    idle_gap(1);
    do_txn(1'b1, 32'((DEPTH - 2) * 4), 3, 1'b0, 32'h0, 4'h0, -1);
    do_txn(1'b0, 32'((DEPTH - 2) * 4), 3, 1'b0, 32'h0, 4'h0, -1);
    do_txn(1'b1, 32'h200, 0, 1'b1, 32'h0BAD_F00D, 4'b0000, -1);
    do_txn(1'b1, 32'h300, 7, 1'b0, 32'h0, 4'h0, 1);
    do_txn(1'b0, 32'h300, 7, 1'b0, 32'h0, 4'h0, -1);

`ifdef CBUS_SRAM_RANGE_CHECK_EN
    do_txn(1'b0, 32'h8000_0000, 2, 1'b0, 32'h0, 4'h0, -1);
    check("err_set", 64'(err), 64'h1);
    do_txn(1'b1, 32'h4000_0040, 1, 1'b0, 32'h0, 4'h0, -1);
    do_txn(1'b0, 32'h0000_0040, 1, 1'b0, 32'h0, 4'h0, -1);
`endif

    for (int t = 0; t < 60; t++) begin
      ra = $urandom;
`ifdef CBUS_SRAM_RANGE_CHECK_EN
      if ($urandom_range(0, 7) != 0) ra[31:AB+2] = '0;
`endif
      do_txn(1'($urandom), ra, int'($urandom_range(0, 15)), 1'b0, 32'h0, 4'h0, -1);
      if ($urandom_range(0, 1) == 1) idle_gap(int'($urandom_range(1, 3)));
    end

`ifdef CBUS_SRAM_RANGE_CHECK_EN
    check("err_sticky", 64'(err), 64'h1);
    @(negedge clk);
    creq.valid = 1'b0;
    resetn     = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("err_clr", 64'(err), 64'h0);
`endif

    idle_gap(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
